mac_fir_sequencer: RTL and testbench

Time-multiplexes one combinational signed multiply-add unit (c = a*b + din, 7x6 -> 13 bit) to compute an NUM_TAPS-tap FIR output per input sample. The block owns the sample delay line and coefficient register file, and steps the shared MAC once per tap. It accumulates through the MAC's din input and presents one registered result per sample. It sits between the sample source and downstream filter stages; the MAC instance lives outside and connects through the mac_* ports.

---
 rtl/mac_fir_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_mac_fir_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_fir_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mac_fir_sequencer
//  Purpose  : Drives one external signed multiply-add unit (c = a*b + din),
//             stepping it once per tap to produce an NUM_TAPS-tap FIR output
//             for every accepted input sample. The block owns the sample delay
//             line and the coefficient register file. Partial sums go back
//             into the MAC through mac_din. Each finished sum is latched into
//             y_out.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   system clock, rising edge
//    reset_n       in   asynchronous active-low reset
//    sample_in     in   signed input sample (A_WIDTH)
//    sample_valid  in   sample_in valid this cycle
//    coef_we       in   coefficient write strobe
//    coef_addr     in   coefficient index (ADDR_W)
//    coef_data     in   signed coefficient value (B_WIDTH)
//    clr_flags     in   clears overrun and cfg_err
//    mac_a         out  MAC a operand: d[k] in RUN, else 0
//    mac_b         out  MAC b operand: coef[k] in RUN, else 0
//    mac_din       out  MAC addend: running accumulator in RUN, else 0
//    mac_c         in   MAC result (A_WIDTH+B_WIDTH)
//    y_out         out  registered signed filter output
//    y_valid       out  one-cycle pulse, y_out updated
//    busy          out  high while a sample is being processed
//    overrun       out  sticky: a sample arrived while busy and was dropped
//    cfg_err       out  sticky: a coefficient write was rejected
// ============================================================================
module mac_fir_sequencer #(
    parameter int A_WIDTH  = 7,
    parameter int B_WIDTH  = 6,
    parameter int NUM_TAPS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic signed [A_WIDTH-1:0]           sample_in,
    input  logic                                sample_valid,
    input  logic                                coef_we,
    input  logic        [ADDR_W-1:0]            coef_addr,
    input  logic signed [B_WIDTH-1:0]           coef_data,
    input  logic                                clr_flags,
    output logic signed [A_WIDTH-1:0]           mac_a,
    output logic signed [B_WIDTH-1:0]           mac_b,
    output logic signed [A_WIDTH+B_WIDTH-1:0]   mac_din,
    input  logic signed [A_WIDTH+B_WIDTH-1:0]   mac_c,
    output logic signed [A_WIDTH+B_WIDTH-1:0]   y_out,
    output logic                                y_valid,
    output logic                                busy,
    output logic                                overrun,
    output logic                                cfg_err
);

    localparam int                c_Y_W      = A_WIDTH + B_WIDTH;
    localparam logic [ADDR_W-1:0] c_LAST_TAP = ADDR_W'(NUM_TAPS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                     r_state;
    logic signed [A_WIDTH-1:0]  r_dly  [NUM_TAPS];
    logic signed [B_WIDTH-1:0]  r_coef [NUM_TAPS];
    logic signed [c_Y_W-1:0]    r_acc;
    logic signed [c_Y_W-1:0]    r_y;
    logic        [ADDR_W-1:0]   r_k;
    logic                       r_y_valid;
    logic                       r_busy;
    logic                       r_overrun;
    logic                       r_cfg_err;

    logic signed [A_WIDTH-1:0]  w_dly_sel;
    logic signed [B_WIDTH-1:0]  w_coef_sel;
    logic                       w_addr_ok;
    logic                       w_coef_wr_ok;
    logic                       w_cfg_err_set;
    logic                       w_overrun_set;

    // Tap selection and address range check are done by explicit compare
    // against each tap index so that ADDR_W may be wider than needed to
    // address NUM_TAPS without out-of-range array indexing.
    always_comb begin
        w_dly_sel  = '0;
        w_coef_sel = '0;
        w_addr_ok  = 1'b0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (r_k == ADDR_W'(i)) begin
                w_dly_sel  = r_dly[i];
                w_coef_sel = r_coef[i];
            end
            if (coef_addr == ADDR_W'(i)) begin
                w_addr_ok = 1'b1;
            end
        end
    end

    // A write in the cycle a sample is accepted sees the IDLE->RUN transition
    // and is treated as a write while busy.
    assign w_coef_wr_ok  = coef_we && (r_state == S_IDLE) && !sample_valid && w_addr_ok;
    assign w_cfg_err_set = coef_we && !w_coef_wr_ok;
    assign w_overrun_set = sample_valid && (r_state == S_RUN);

    assign mac_a   = (r_state == S_RUN) ? w_dly_sel  : '0;
    assign mac_b   = (r_state == S_RUN) ? w_coef_sel : '0;
    assign mac_din = (r_state == S_RUN) ? r_acc      : '0;

    assign y_out   = r_y;
    assign y_valid = r_y_valid;
    assign busy    = r_busy;
    assign overrun = r_overrun;
    assign cfg_err = r_cfg_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_y       <= '0;
            r_k       <= '0;
            r_y_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_cfg_err <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_dly[i]  <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            r_y_valid <= 1'b0;

            if (w_coef_wr_ok) begin
                for (int i = 0; i < NUM_TAPS; i++) begin
                    if (coef_addr == ADDR_W'(i)) begin
                        r_coef[i] <= coef_data;
                    end
                end
            end

            // Set beats clear when both happen in one cycle.
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clr_flags) begin
                r_overrun <= 1'b0;
            end

            if (w_cfg_err_set) begin
                r_cfg_err <= 1'b1;
            end else if (clr_flags) begin
                r_cfg_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (sample_valid) begin
                        r_dly[0] <= sample_in;
                        for (int i = 1; i < NUM_TAPS; i++) begin
                            r_dly[i] <= r_dly[i-1];
                        end
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= mac_c;
                    r_k   <= r_k + ADDR_W'(1);
                    if (r_k == c_LAST_TAP) begin
                        r_y       <= mac_c;
                        r_y_valid <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_fir_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_fir_sequencer
//  Purpose  : Self-checking bench for mac_fir_sequencer. Provides the external
//             7x6 signed MAC, applies a table of directed samples with
//             hand-computed FIR results, and runs hand-written sequences for
//             back-to-back, overrun, coefficient-error and mid-run reset cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_fir_sequencer;

    localparam int c_AW   = 7;
    localparam int c_BW   = 6;
    localparam int c_TAPS = 4;
    localparam int c_ADW  = 3;
    localparam int c_YW   = c_AW + c_BW;

    logic                     clk;
    logic                     reset_n;
    logic signed [c_AW-1:0]   sample_in;
    logic                     sample_valid;
    logic                     coef_we;
    logic        [c_ADW-1:0]  coef_addr;
    logic signed [c_BW-1:0]   coef_data;
    logic                     clr_flags;
    logic signed [c_AW-1:0]   mac_a;
    logic signed [c_BW-1:0]   mac_b;
    logic signed [c_YW-1:0]   mac_din;
    logic signed [c_YW-1:0]   mac_c;
    logic signed [c_YW-1:0]   y_out;
    logic                     y_valid;
    logic                     busy;
    logic                     overrun;
    logic                     cfg_err;

    int total = 0;
    int bad   = 0;

    mac_fir_sequencer #(
        .A_WIDTH (c_AW),
        .B_WIDTH (c_BW),
        .NUM_TAPS(c_TAPS),
        .ADDR_W  (c_ADW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .clr_flags   (clr_flags),
        .mac_a       (mac_a),
        .mac_b       (mac_b),
        .mac_din     (mac_din),
        .mac_c       (mac_c),
        .y_out       (y_out),
        .y_valid     (y_valid),
        .busy        (busy),
        .overrun     (overrun),
        .cfg_err     (cfg_err)
    );

    // External MAC: sign-extend both operands to the result width, wrap.
    logic signed [c_YW-1:0] w_ea;
    logic signed [c_YW-1:0] w_eb;
    assign w_ea  = mac_a;
    assign w_eb  = mac_b;
    assign mac_c = w_ea * w_eb + mac_din;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = c_ADW'(addr);
        coef_data = c_BW'(data);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
        write_coef(0, c0);
        write_coef(1, c1);
        write_coef(2, c2);
        write_coef(3, c3);
    endtask

    // Waits (bounded) for y_valid; returns number of negedges waited.
    task automatic wait_y(output int y, output int n, output bit ok);
        n = 0;
        while (!y_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = y_valid;
        y  = int'(y_out);
        if (!ok) check("y_valid_timeout", 0, 1);
    endtask

    // Presents one sample for one cycle; lat counts negedges from the
    // sample_valid cycle to the cycle in which y_valid is observed.
    task automatic run_sample(input int s, output int y, output int lat, output bit ok);
        int n;
        sample_in    = c_AW'(s);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        wait_y(y, n, ok);
        lat = n + 1;
    endtask

    typedef struct {
        bit load;
        int c0, c1, c2, c3;
        int smp;
        int exp_y;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int y, lat, n, pulses;
        bit ok;

        // impulse
        tbl[0]  = '{1'b1,   1,   2,   3,   4,  10,    10};
        tbl[1]  = '{1'b0,   0,   0,   0,   0,   0,    20};
        tbl[2]  = '{1'b0,   0,   0,   0,   0,   0,    30};
        tbl[3]  = '{1'b0,   0,   0,   0,   0,   0,    40};
        // flush then convolution
        tbl[4]  = '{1'b0,   0,   0,   0,   0,   0,     0};
        tbl[5]  = '{1'b0,   0,   0,   0,   0,  10,    10};
        tbl[6]  = '{1'b0,   0,   0,   0,   0,  20,    40};
        // all coef -32: flush history [20,10,0,0], then -64 x4 with wrap
        tbl[7]  = '{1'b1, -32, -32, -32, -32,   0,  -960};
        tbl[8]  = '{1'b0,   0,   0,   0,   0,   0,  -960};
        tbl[9]  = '{1'b0,   0,   0,   0,   0,   0,  -640};
        tbl[10] = '{1'b0,   0,   0,   0,   0,   0,     0};
        tbl[11] = '{1'b0,   0,   0,   0,   0, -64,  2048};
        tbl[12] = '{1'b0,   0,   0,   0,   0, -64, -4096};
        tbl[13] = '{1'b0,   0,   0,   0,   0, -64, -2048};
        tbl[14] = '{1'b0,   0,   0,   0,   0, -64,     0};

        reset_n      = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        coef_we      = 1'b0;
        coef_addr    = '0;
        coef_data    = '0;
        clr_flags    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_y_out",   int'(y_out), 0);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_busy",    int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_mac_a",   int'(mac_a), 0);

        // -------- table-driven vectors --------
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].load) load_coefs(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3);
            run_sample(tbl[i].smp, y, lat, ok);
            if (ok) begin
                check($sformatf("vec%0d_y", i), y, tbl[i].exp_y);
                check($sformatf("vec%0d_lat", i), lat, 5);
                check($sformatf("vec%0d_busy_low", i), int'(busy), 0);
            end
        end
        check("table_overrun", int'(overrun), 0);

        // -------- back-to-back acceptance in the y_valid cycle --------
        load_coefs(1, 2, 3, 4);
        for (int i = 0; i < 4; i++) run_sample(0, y, lat, ok);
        run_sample(10, y, lat, ok);
        check("b2b_first_y", y, 10);
        run_sample(20, y, lat, ok);
        check("b2b_second_y", y, 40);
        check("b2b_second_lat", lat, 5);
        check("b2b_overrun", int'(overrun), 0);

        // -------- overrun and write-while-busy during RUN --------
        // history [20,10,0,0]; new sample 5 -> 5*1 + 20*2 + 10*3 = 75
        sample_in    = 7'sd5;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("run_busy", int'(busy), 1);
        @(negedge clk);
        sample_in    = 7'sd99;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        coef_we      = 1'b1;
        coef_addr    = 3'd1;
        coef_data    = 6'sd7;
        @(negedge clk);
        coef_we      = 1'b0;
        check("ovr_set", int'(overrun), 1);
        check("cfg_busy_set", int'(cfg_err), 1);
        wait_y(y, n, ok);
        check("ovr_inflight_y", y, 75);
        // history [0,5,20,10] -> 0 + 10 + 60 + 40 = 110 (coef[1] still 2)
        run_sample(0, y, lat, ok);
        check("ovr_history_y", y, 110);

        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("clr_overrun", int'(overrun), 0);
        check("clr_cfg_err", int'(cfg_err), 0);

        // write in the accept cycle is rejected: [2,0,5,20] -> 2+15+80 = 97
        sample_in    = 7'sd2;
        sample_valid = 1'b1;
        coef_we      = 1'b1;
        coef_addr    = 3'd0;
        coef_data    = 6'sd7;
        @(negedge clk);
        sample_valid = 1'b0;
        coef_we      = 1'b0;
        check("accept_wr_cfg_err", int'(cfg_err), 1);
        check("accept_wr_overrun", int'(overrun), 0);
        wait_y(y, n, ok);
        check("accept_wr_y", y, 97);

        // out-of-range address with clr in the same cycle: set wins
        clr_flags = 1'b1;
        coef_we   = 1'b1;
        coef_addr = 3'd5;
        coef_data = 6'sd7;
        @(negedge clk);
        clr_flags = 1'b0;
        coef_we   = 1'b0;
        check("addr5_cfg_err", int'(cfg_err), 1);
        // [0,2,0,5] -> 0 + 4 + 0 + 20 = 24 (coef[1] not aliased)
        run_sample(0, y, lat, ok);
        check("addr5_coef_kept_y", y, 24);

        // -------- reset mid-RUN at k == 2 --------
        sample_in    = 7'sd9;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy",    int'(busy), 0);
        check("midrst_y_valid", int'(y_valid), 0);
        check("midrst_y_out",   int'(y_out), 0);
        check("midrst_cfg_err", int'(cfg_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (y_valid) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        check("midrst_y_hold", int'(y_out), 0);
        load_coefs(1, 2, 3, 4);
        run_sample(3, y, lat, ok);
        check("midrst_next_y", y, 3);
        check("midrst_next_lat", lat, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
